input_v_sweep_ctrl: RTL and testbench

// Sequences the shared single-port input-voltage buffer between two requesters: the exchange

---
 rtl/input_v_sweep_ctrl.sv | 153 +++++++++++++++
 tb/tb_input_v_sweep_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/input_v_sweep_ctrl.sv
// Arbitrates the shared input-voltage buffer between exchange-side write sweeps and
// solver-side read sweeps, tagging returned read data with its slot index.
module input_v_sweep_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned N_ENTRY    = 10,
  parameter int unsigned INI_ADDR   = 0,
  parameter int unsigned STEP_CYC   = 2,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_sta,
  input  logic                  i_exch_sig,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic                  o_rd_valid,
  output logic [ADDR_WIDTH-1:0] o_rd_idx,
  output logic                  o_wr_done,
  output logic                  o_rd_done,
  output logic                  o_overrun,
  output logic                  o_busy
);

  localparam int unsigned AW   = ADDR_WIDTH;
  localparam int unsigned CMAX = (STEP_CYC > RD_LAT) ? STEP_CYC : RD_LAT;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DRAIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_k, w_k_nxt;
  logic [CW-1:0]   r_c, w_c_nxt;
  logic            r_wr_pend, r_rd_pend;
  logic            w_clr_wr, w_clr_rd;
  logic            w_step_last, w_sweep_last;
  logic            w_active_nxt, w_en_nxt, w_we_nxt, w_wr_done_nxt, w_rd_done_nxt, w_busy_nxt;
  logic [AW-1:0]   w_addr_nxt;
  logic            w_wr_pend_kept, w_rd_pend_kept, w_overrun_nxt;
  logic [RD_LAT-1:0] r_pipe_v;
  logic [AW-1:0]   r_pipe_idx [RD_LAT];

  assign w_step_last  = (r_c == CW'(STEP_CYC - 1));
  assign w_sweep_last = w_step_last && (r_k == AW'(N_ENTRY - 1));

  // State and sweep counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_c     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_c     <= w_c_nxt;
    end
  end

  // Next state: write wins over read so the solver sees the freshest samples
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_c_nxt     = r_c;
    w_clr_wr    = 1'b0;
    w_clr_rd    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_k_nxt = '0;
        w_c_nxt = '0;
        if (r_wr_pend) begin
          w_state_nxt = S_WR;
          w_clr_wr    = 1'b1;
        end else if (r_rd_pend) begin
          w_state_nxt = S_RD;
          w_clr_rd    = 1'b1;
        end
      end
      S_WR, S_RD: begin
        if (w_sweep_last) begin
          w_state_nxt = (r_state == S_WR) ? S_IDLE : S_DRAIN;
          w_k_nxt     = '0;
          w_c_nxt     = '0;
        end else if (w_step_last) begin
          w_k_nxt = r_k + AW'(1);
          w_c_nxt = '0;
        end else begin
          w_c_nxt = r_c + CW'(1);
        end
      end
      S_DRAIN: begin
        // RD_LAT clocks after the sweep guarantees the last read has left the pipe
        if (r_c == CW'(RD_LAT - 1)) begin
          w_state_nxt = S_IDLE;
          w_c_nxt     = '0;
        end else begin
          w_c_nxt = r_c + CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the state being entered, so registered outputs align with it
  always_comb begin
    w_active_nxt   = (w_state_nxt == S_WR) || (w_state_nxt == S_RD);
    w_en_nxt       = w_active_nxt && (w_c_nxt == '0);
    w_we_nxt       = w_en_nxt && (w_state_nxt == S_WR);
    w_addr_nxt     = w_active_nxt ? (AW'(INI_ADDR) + w_k_nxt) : o_mem_addr;
    w_wr_done_nxt  = (r_state == S_WR) && (w_state_nxt == S_IDLE);
    w_rd_done_nxt  = (r_state == S_DRAIN) && (w_state_nxt == S_IDLE);
    w_busy_nxt     = (w_state_nxt != S_IDLE);
    w_wr_pend_kept = r_wr_pend && !w_clr_wr;
    w_rd_pend_kept = r_rd_pend && !w_clr_rd;
    w_overrun_nxt  = (i_sta && w_rd_pend_kept) || (i_exch_sig && w_wr_pend_kept);
  end

  // Registered outputs, request flags and read-tag pipe
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_mem_addr <= AW'(INI_ADDR);
      o_mem_en   <= 1'b0;
      o_mem_we   <= 1'b0;
      o_wr_done  <= 1'b0;
      o_rd_done  <= 1'b0;
      o_overrun  <= 1'b0;
      o_busy     <= 1'b0;
      r_wr_pend  <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_pipe_v   <= '0;
      for (int i = 0; i < RD_LAT; i++) r_pipe_idx[i] <= '0;
    end else begin
      o_mem_addr <= w_addr_nxt;
      o_mem_en   <= w_en_nxt;
      o_mem_we   <= w_we_nxt;
      o_wr_done  <= w_wr_done_nxt;
      o_rd_done  <= w_rd_done_nxt;
      o_overrun  <= w_overrun_nxt;
      o_busy     <= w_busy_nxt;
      r_wr_pend  <= w_wr_pend_kept || i_exch_sig;
      r_rd_pend  <= w_rd_pend_kept || i_sta;
      r_pipe_v[0]   <= o_mem_en && !o_mem_we;
      r_pipe_idx[0] <= (o_mem_en && !o_mem_we) ? (o_mem_addr - AW'(INI_ADDR)) : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_v[i]   <= r_pipe_v[i-1];
        r_pipe_idx[i] <= r_pipe_idx[i-1];
      end
    end
  end

  assign o_rd_valid = r_pipe_v[RD_LAT-1];
  assign o_rd_idx   = r_pipe_idx[RD_LAT-1];

endmodule

// File: tb/tb_input_v_sweep_ctrl.sv
// Directed bench for input_v_sweep_ctrl: default instance plus a STEP_CYC=1/RD_LAT=3/N_ENTRY=16 instance.
module tb_input_v_sweep_ctrl;

  typedef logic [14:0] obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, sta, exch, sta6, exch6;
  logic [3:0] mem_addr, rd_idx, mem_addr6, rd_idx6;
  logic       mem_en, mem_we, rd_valid, wr_done, rd_done, overrun, busy;
  logic       mem_en6, mem_we6, rd_valid6, wr_done6, rd_done6, overrun6, busy6;

  int n_cmp = 0;
  int n_err = 0;

  input_v_sweep_ctrl u_dut (
    .i_clk(clk), .i_rst(rst), .i_sta(sta), .i_exch_sig(exch),
    .o_mem_addr(mem_addr), .o_mem_en(mem_en), .o_mem_we(mem_we),
    .o_rd_valid(rd_valid), .o_rd_idx(rd_idx), .o_wr_done(wr_done),
    .o_rd_done(rd_done), .o_overrun(overrun), .o_busy(busy)
  );

  input_v_sweep_ctrl #(
    .ADDR_WIDTH(4), .N_ENTRY(16), .INI_ADDR(0), .STEP_CYC(1), .RD_LAT(3)
  ) u_dut6 (
    .i_clk(clk), .i_rst(rst), .i_sta(sta6), .i_exch_sig(exch6),
    .o_mem_addr(mem_addr6), .o_mem_en(mem_en6), .o_mem_we(mem_we6),
    .o_rd_valid(rd_valid6), .o_rd_idx(rd_idx6), .o_wr_done(wr_done6),
    .o_rd_done(rd_done6), .o_overrun(overrun6), .o_busy(busy6)
  );

  function automatic obs_t obs_a();
    return {mem_addr, mem_en, mem_we, rd_valid, rd_idx, wr_done, rd_done, overrun, busy};
  endfunction

  function automatic obs_t obs_b();
    return {mem_addr6, mem_en6, mem_we6, rd_valid6, rd_idx6, wr_done6, rd_done6, overrun6, busy6};
  endfunction

  function automatic obs_t pack(int a, logic en, logic we, logic rv, int idx,
                                logic wd, logic rdn, logic ov, logic bz);
    return {4'(a), en, we, rv, 4'(idx), wd, rdn, ov, bz};
  endfunction

  // Expected outputs j clocks after a read sweep's first strobe
  function automatic obs_t exp_rd(int j, int n, int s, int l, int ini);
    int  ns = n * s;
    int  t  = j - l;
    logic rv = (t >= 0) && (t < ns) && ((t % s) == 0);
    return pack((j < ns) ? ini + j / s : ini + n - 1,
                (j < ns) && ((j % s) == 0), 1'b0,
                rv, rv ? t / s : 0,
                1'b0, (j == ns + l), 1'b0, (j < ns + l));
  endfunction

  // Expected outputs j clocks after a write sweep's first strobe
  function automatic obs_t exp_wr(int j, int n, int s, int ini);
    int   ns = n * s;
    logic en = (j < ns) && ((j % s) == 0);
    return pack((j < ns) ? ini + j / s : ini + n - 1, en, en, 1'b0, 0,
                (j == ns), 1'b0, 1'b0, (j < ns));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e;
    rst = 1'b1; sta = 1'b0; exch = 1'b0; sta6 = 1'b0; exch6 = 1'b0;
    tick(); tick();
    e = pack(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (obs_a() !== e) begin n_err++; $display("FAIL reset_a got=%h exp=%h", obs_a(), e); end
    n_cmp++;
    if (obs_b() !== e) begin n_err++; $display("FAIL reset_b got=%h exp=%h", obs_b(), e); end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (obs_a() !== e) begin n_err++; $display("FAIL reset_idle got=%h exp=%h", obs_a(), e); end
  endtask

  task automatic test_write_sweep();
    obs_t e;
    exch = 1'b1; tick(); exch = 1'b0;
    e = pack(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (obs_a() !== e) begin n_err++; $display("FAIL wr_latency got=%h exp=%h", obs_a(), e); end
    tick();
    for (int j = 0; j <= 21; j++) begin
      e = exp_wr(j, 10, 2, 0);
      n_cmp++;
      if (obs_a() !== e) begin n_err++; $display("FAIL wr_sweep j=%0d got=%h exp=%h", j, obs_a(), e); end
      tick();
    end
  endtask

  task automatic test_read_sweep();
    obs_t e;
    sta = 1'b1; tick(); sta = 1'b0;
    e = pack(9, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (obs_a() !== e) begin n_err++; $display("FAIL rd_latency got=%h exp=%h", obs_a(), e); end
    tick();
    for (int j = 0; j <= 23; j++) begin
      e = exp_rd(j, 10, 2, 2, 0);
      n_cmp++;
      if (obs_a() !== e) begin n_err++; $display("FAIL rd_sweep j=%0d got=%h exp=%h", j, obs_a(), e); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    sta = 1'b1; exch = 1'b1; tick(); sta = 1'b0; exch = 1'b0;
    tick();
    for (int j = 0; j <= 20; j++) begin
      e = exp_wr(j, 10, 2, 0);
      n_cmp++;
      if (obs_a() !== e) begin n_err++; $display("FAIL b2b_wr j=%0d got=%h exp=%h", j, obs_a(), e); end
      tick();
    end
    for (int j = 0; j <= 23; j++) begin
      e = exp_rd(j, 10, 2, 2, 0);
      n_cmp++;
      if (obs_a() !== e) begin n_err++; $display("FAIL b2b_rd j=%0d got=%h exp=%h", j, obs_a(), e); end
      tick();
    end
  endtask

  task automatic test_requeue_overrun();
    obs_t e;
    sta = 1'b1; tick(); sta = 1'b0;
    tick();
    for (int j = 0; j <= 22; j++) begin
      e = exp_rd(j, 10, 2, 2, 0);
      e[1] = (j == 10);
      n_cmp++;
      if (obs_a() !== e) begin n_err++; $display("FAIL requeue_first j=%0d got=%h exp=%h", j, obs_a(), e); end
      sta = (j == 5) || (j == 9);
      tick();
      sta = 1'b0;
    end
    for (int j = 0; j <= 24; j++) begin
      e = exp_rd(j, 10, 2, 2, 0);
      n_cmp++;
      if (obs_a() !== e) begin n_err++; $display("FAIL requeue_second j=%0d got=%h exp=%h", j, obs_a(), e); end
      tick();
    end
  endtask

  task automatic test_reset_mid_sweep();
    obs_t e;
    sta = 1'b1; tick(); sta = 1'b0;
    tick();
    for (int j = 0; j <= 7; j++) begin
      e = exp_rd(j, 10, 2, 2, 0);
      n_cmp++;
      if (obs_a() !== e) begin n_err++; $display("FAIL midrst_pre j=%0d got=%h exp=%h", j, obs_a(), e); end
      exch = (j == 3);
      sta  = (j == 5);
      tick();
      exch = 1'b0; sta = 1'b0;
    end
    e = exp_rd(8, 10, 2, 2, 0);
    n_cmp++;
    if (obs_a() !== e) begin n_err++; $display("FAIL midrst_k4 got=%h exp=%h", obs_a(), e); end
    rst = 1'b1; tick(); rst = 1'b0;
    e = pack(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int j = 0; j <= 30; j++) begin
      n_cmp++;
      if (obs_a() !== e) begin n_err++; $display("FAIL midrst_post j=%0d got=%h exp=%h", j, obs_a(), e); end
      tick();
    end
  endtask

  task automatic test_fast_step();
    obs_t e;
    sta6 = 1'b1; tick(); sta6 = 1'b0;
    e = pack(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (obs_b() !== e) begin n_err++; $display("FAIL fast_latency got=%h exp=%h", obs_b(), e); end
    tick();
    for (int j = 0; j <= 21; j++) begin
      e = exp_rd(j, 16, 1, 3, 0);
      n_cmp++;
      if (obs_b() !== e) begin n_err++; $display("FAIL fast_sweep j=%0d got=%h exp=%h", j, obs_b(), e); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_sweep();
    test_read_sweep();
    test_back_to_back();
    test_requeue_overrun();
    test_reset_mid_sweep();
    test_fast_step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
